pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central hazard controller for the 5-stage pipeline. It sequences the PC and the IF/ID, ID/EX and EX/MEM pipeline registers by producing write-enables and flushes, and it selects forwarding sources for the EX-stage ALU operands. It also runs the overflow-exception drain/vector sequence. Sequential state updates on the same falling edge of Clk as the pipeline registers, so decisions made during a cycle take effect at that cycle's negedge.

Parameters:
EXC_VECTOR, 32'h00000180, PC loaded after an overflow exception drains
DRAIN_CYCLES, 2, cycles held in EXC_DRAIN before vectoring (1..15)
CNT_W, 16, width of performance counters

Ports:
Clk  input  1  pipeline clock; all state changes on negedge Clk
Reset  input  1  synchronous, active-high reset, sampled at negedge Clk
ID_Rs, ID_Rt  input  5 each  source registers of the instruction in ID
ID_UsesRt  input  1  ID instruction reads rt
E_Rs, E_Rt  input  5 each  source registers of the instruction in EX
E_Rw, E_RegWr, E_MemtoReg  input  5/1/1  EX-stage destination, write and load flags
M_Rw, M_RegWr  input  5/1  MEM-stage destination and write flag
M_Jump, M_Branch, M_Zero, M_Overflow  input  1 each  MEM-stage resolution flags
M_Jtarg, M_Btarg  input  32 each  MEM-stage jump and branch targets
W_Rw, W_RegWr  input  5/1  WB-stage destination and write flag
PC_Write, IFID_Write  output  1 each  PC and IF/ID load enables
IFID_Flush, IDEX_Flush, EXMEM_Flush  output  1 each  zero the control fields of each register
PC_Sel  output  2  00 = PC+4, 01 = PC_Target, 10 = EXC_VECTOR
PC_Target  output  32  M_Jump ? M_Jtarg : M_Btarg
FwdA, FwdB  output  2 each  00 = register file, 01 = M_ALUout, 10 = WB data
Exc_Pending  output  1  high from exception detection until vector is taken
StallCnt, FlushCnt  output  CNT_W each  saturating performance counters

Behaviour:
- States: RUN, EXC_DRAIN, EXC_VEC. Reset returns to RUN, drain counter = 0, StallCnt = FlushCnt = 0, Exc_Pending = 0.
- While Reset = 1 (combinational): PC_Write = 0, IFID_Write = 0, all three flushes = 1, PC_Sel = 00, FwdA = FwdB = 00.
- RUN priority, highest first:
  - Exception: M_Overflow & M_RegWr.
    - All three flushes = 1, PC_Write = 0, IFID_Write = 0.
    - Next state EXC_DRAIN, drain counter = DRAIN_CYCLES-1, Exc_Pending <= 1, FlushCnt += 1.
  - Redirect: M_Jump | (M_Branch & M_Zero).
    - PC_Sel = 01, PC_Write = 1, all three flushes = 1.
    - FlushCnt += 1. Stay in RUN.
    - Jump takes priority over Branch for PC_Target.
  - Load-use: E_MemtoReg & E_RegWr & E_Rw != 0 & (E_Rw == ID_Rs | (ID_UsesRt & E_Rw == ID_Rt)).
    - PC_Write = 0, IFID_Write = 0, IDEX_Flush = 1.
    - StallCnt += 1. Stay in RUN.
    - Exactly one bubble per hazard, because the load reaches MEM next cycle.
  - Otherwise: PC_Write = IFID_Write = 1, flushes = 0, PC_Sel = 00.
- A redirect in the same cycle as a load-use stall: redirect wins and no stall is counted.
- EXC_DRAIN:
  - PC_Write = IFID_Write = 0, all flushes = 1.
  - Counter decrements each negedge; at 0, next state is EXC_VEC.
  - All M_ inputs are ignored, so a nested overflow is ignored.
- EXC_VEC:
  - PC_Sel = 10, PC_Write = 1, IFID_Write = 1, flushes = 0.
  - Exc_Pending <= 0. Next state RUN.
- Forwarding (combinational, independent of state):
  - FwdA = 01 if M_RegWr & M_Rw != 0 & M_Rw == E_Rs.
  - Else 10 if W_RegWr & W_Rw != 0 & W_Rw == E_Rs.
  - Else 00.
  - FwdB uses the same rule on E_Rt. MEM has priority over WB. Register 0 is never forwarded.
- Counters saturate at all-ones with no wrap. Reset mid-exception returns to RUN immediately and clears Exc_Pending.

Test Plan:
- Reset held 2 cycles, then released with no hazards -> PC_Write = 1, IFID_Write = 1, flushes = 0, PC_Sel = 00, counters = 0.
- E_MemtoReg = 1, E_RegWr = 1, E_Rw = 8, ID_Rs = 8 for one cycle -> PC_Write = 0, IFID_Write = 0, IDEX_Flush = 1, StallCnt = 1. Repeat with E_Rw = 0 -> no stall.
- M_Branch = 1, M_Zero = 1, M_Btarg = 32'h00400040, asserted together with a load-use hazard -> PC_Sel = 01, PC_Target = 32'h00400040, all flushes = 1, FlushCnt = 1, StallCnt unchanged. Then M_Jump = 1 and M_Branch = 1 together -> PC_Target = M_Jtarg.
- M_Overflow = 1, M_RegWr = 1 with DRAIN_CYCLES = 2 -> Exc_Pending = 1 and flushes for 3 cycles (detect + 2 drain), then one cycle with PC_Sel = 10, then RUN with Exc_Pending = 0. Assert Reset during drain -> RUN next negedge.
- E_Rs = 5, M_Rw = 5, W_Rw = 5, both RegWr = 1 -> FwdA = 01. Drop M_RegWr -> FwdA = 10. E_Rt = 0 with M_Rw = 0 -> FwdB = 00.
- Force 2^CNT_W + 3 consecutive load-use stalls -> StallCnt holds at all-ones.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: PC/IF-ID enables, stage flushes, EX forwarding
// selects and the overflow-exception drain/vector sequence. State updates on negedge Clk.
module pipe_hazard_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic [4:0]       E_Rs,
  input  logic [4:0]       E_Rt,
  input  logic [4:0]       E_Rw,
  input  logic             E_RegWr,
  input  logic             E_MemtoReg,
  input  logic [4:0]       M_Rw,
  input  logic             M_RegWr,
  input  logic             M_Jump,
  input  logic             M_Branch,
  input  logic             M_Zero,
  input  logic             M_Overflow,
  input  logic [31:0]      M_Jtarg,
  input  logic [31:0]      M_Btarg,
  input  logic [4:0]       W_Rw,
  input  logic             W_RegWr,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Flush,
  output logic [1:0]       PC_Sel,
  output logic [31:0]      PC_Target,
  output logic [1:0]       FwdA,
  output logic [1:0]       FwdB,
  output logic             Exc_Pending,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  typedef enum logic [1:0] {StRun, StExcDrain, StExcVec} state_e;

  localparam logic [3:0] DrainInit = 4'(DRAIN_CYCLES - 1);

  state_e           state_q;
  logic [3:0]       drain_q;
  logic             exc_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic exc_det, redirect, load_use;
  logic stall_inc, flush_inc;

  assign exc_det  = M_Overflow & M_RegWr;
  assign redirect = M_Jump | (M_Branch & M_Zero);
  assign load_use = E_MemtoReg & E_RegWr & (E_Rw != 5'd0) &
                    ((E_Rw == ID_Rs) | (ID_UsesRt & (E_Rw == ID_Rt)));

  assign PC_Target   = M_Jump ? M_Jtarg : M_Btarg;
  assign Exc_Pending = exc_q;
  assign StallCnt    = stall_cnt_q;
  assign FlushCnt    = flush_cnt_q;

  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    PC_Sel      = 2'b00;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (Reset) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Flush = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (exc_det) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
            flush_inc   = 1'b1;
          end else if (redirect) begin
            // Redirect squashes the younger load-use stall, so no stall is counted.
            PC_Sel      = 2'b01;
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
            flush_inc   = 1'b1;
          end else if (load_use) begin
            PC_Write   = 1'b0;
            IFID_Write = 1'b0;
            IDEX_Flush = 1'b1;
            stall_inc  = 1'b1;
          end
        end
        StExcDrain: begin
          PC_Write    = 1'b0;
          IFID_Write  = 1'b0;
          IFID_Flush  = 1'b1;
          IDEX_Flush  = 1'b1;
          EXMEM_Flush = 1'b1;
        end
        StExcVec: PC_Sel = 2'b10;
        default: ;
      endcase
    end
  end

  // MEM result has priority over WB; r0 is never forwarded.
  always_comb begin
    FwdA = 2'b00;
    FwdB = 2'b00;
    if (!Reset) begin
      if (M_RegWr && M_Rw != 5'd0 && M_Rw == E_Rs)      FwdA = 2'b01;
      else if (W_RegWr && W_Rw != 5'd0 && W_Rw == E_Rs) FwdA = 2'b10;
      if (M_RegWr && M_Rw != 5'd0 && M_Rw == E_Rt)      FwdB = 2'b01;
      else if (W_RegWr && W_Rw != 5'd0 && W_Rw == E_Rt) FwdB = 2'b10;
    end
  end

  always_ff @(negedge Clk) begin
    if (Reset) begin
      state_q     <= StRun;
      drain_q     <= 4'd0;
      exc_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      unique case (state_q)
        StRun: begin
          if (exc_det) begin
            state_q <= StExcDrain;
            drain_q <= DrainInit;
            exc_q   <= 1'b1;
          end
        end
        StExcDrain: begin
          if (drain_q == 4'd0) state_q <= StExcVec;
          else                 drain_q <= drain_q - 4'd1;
        end
        StExcVec: begin
          state_q <= StRun;
          exc_q   <= 1'b0;
        end
        default: state_q <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: inputs change just after negedge, outputs checked at posedge.
module tb_pipe_hazard_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  ID_Rs, ID_Rt, E_Rs, E_Rt, E_Rw, M_Rw, W_Rw;
  logic        ID_UsesRt, E_RegWr, E_MemtoReg, M_RegWr, W_RegWr;
  logic        M_Jump, M_Branch, M_Zero, M_Overflow;
  logic [31:0] M_Jtarg, M_Btarg;
  logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, Exc_Pending;
  logic [1:0]  PC_Sel, FwdA, FwdB;
  logic [31:0] PC_Target;
  logic [15:0] StallCnt, FlushCnt;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  pipe_hazard_ctrl dut (
    .Clk(Clk), .Reset(Reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .E_Rs(E_Rs), .E_Rt(E_Rt), .E_Rw(E_Rw), .E_RegWr(E_RegWr), .E_MemtoReg(E_MemtoReg),
    .M_Rw(M_Rw), .M_RegWr(M_RegWr), .M_Jump(M_Jump), .M_Branch(M_Branch), .M_Zero(M_Zero),
    .M_Overflow(M_Overflow), .M_Jtarg(M_Jtarg), .M_Btarg(M_Btarg),
    .W_Rw(W_Rw), .W_RegWr(W_RegWr),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush), .PC_Sel(PC_Sel),
    .PC_Target(PC_Target), .FwdA(FwdA), .FwdB(FwdB), .Exc_Pending(Exc_Pending),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {ID_Rs, ID_Rt, E_Rs, E_Rt, E_Rw, M_Rw, W_Rw} = '0;
    {ID_UsesRt, E_RegWr, E_MemtoReg, M_RegWr, W_RegWr} = '0;
    {M_Jump, M_Branch, M_Zero, M_Overflow} = '0;
    M_Jtarg = 32'h0040_0100;
    M_Btarg = 32'h0040_0040;
  endtask

  task automatic next_cycle();
    @(negedge Clk);
    #1;
  endtask

  task automatic mid();
    @(posedge Clk);
  endtask

  function automatic logic [31:0] flushes();
    return {29'd0, IFID_Flush, IDEX_Flush, EXMEM_Flush};
  endfunction

  task automatic load_use_rs(input logic [4:0] rw);
    E_MemtoReg = 1'b1; E_RegWr = 1'b1; E_Rw = rw; ID_Rs = rw;
  endtask

  initial begin
    idle();
    Reset = 1'b1;
    E_Rs = 5'd5; M_Rw = 5'd5; M_RegWr = 1'b1;
    mid();
    check("rst_pcw", PC_Write, 0);
    check("rst_ifidw", IFID_Write, 0);
    check("rst_flush", flushes(), 3'b111);
    check("rst_pcsel", PC_Sel, 0);
    check("rst_fwda", FwdA, 0);
    next_cycle(); idle(); mid();
    next_cycle(); Reset = 1'b0; mid();
    check("run_pcw", PC_Write, 1);
    check("run_ifidw", IFID_Write, 1);
    check("run_flush", flushes(), 0);
    check("run_pcsel", PC_Sel, 0);
    check("run_stallcnt", StallCnt, 0);
    check("run_flushcnt", FlushCnt, 0);
    check("run_exc", Exc_Pending, 0);

    // Load-use on rs, then on rw=0, then on rt with and without ID_UsesRt.
    next_cycle(); load_use_rs(5'd8); mid();
    check("lu_pcw", PC_Write, 0);
    check("lu_ifidw", IFID_Write, 0);
    check("lu_flush", flushes(), 3'b010);
    next_cycle(); idle(); mid();
    check("lu_stallcnt", StallCnt, 1);
    check("lu_released", PC_Write, 1);
    next_cycle(); load_use_rs(5'd0); mid();
    check("lu_r0_pcw", PC_Write, 1);
    check("lu_r0_flush", flushes(), 0);
    next_cycle(); idle(); E_MemtoReg = 1; E_RegWr = 1; E_Rw = 9; ID_Rt = 9; ID_UsesRt = 1; mid();
    check("lu_rt_pcw", PC_Write, 0);
    next_cycle(); ID_UsesRt = 0; mid();
    check("lu_rt_nouse_pcw", PC_Write, 1);
    next_cycle(); idle(); mid();
    check("lu_stallcnt2", StallCnt, 2);

    // Branch redirect beats load-use; then jump beats branch.
    next_cycle(); load_use_rs(5'd8); M_Branch = 1; M_Zero = 1; mid();
    check("br_pcsel", PC_Sel, 1);
    check("br_target", PC_Target, 32'h0040_0040);
    check("br_flush", flushes(), 3'b111);
    check("br_pcw", PC_Write, 1);
    next_cycle(); idle(); mid();
    check("br_flushcnt", FlushCnt, 1);
    check("br_stallcnt", StallCnt, 2);
    next_cycle(); M_Branch = 1; M_Zero = 0; mid();
    check("br_nottaken_pcsel", PC_Sel, 0);
    next_cycle(); M_Jump = 1; M_Branch = 1; mid();
    check("jmp_pcsel", PC_Sel, 1);
    check("jmp_target", PC_Target, 32'h0040_0100);
    next_cycle(); idle(); mid();
    check("jmp_flushcnt", FlushCnt, 2);

    // Overflow exception (with a coincident jump), nested overflow held during drain.
    next_cycle(); M_Overflow = 1; M_RegWr = 1; M_Jump = 1; mid();
    check("exc_det_flush", flushes(), 3'b111);
    check("exc_det_pcw", PC_Write, 0);
    check("exc_det_ifidw", IFID_Write, 0);
    check("exc_det_pcsel", PC_Sel, 0);
    for (int i = 0; i < 2; i++) begin
      next_cycle(); mid();
      check("exc_drain_pend", Exc_Pending, 1);
      check("exc_drain_flush", flushes(), 3'b111);
      check("exc_drain_pcw", PC_Write, 0);
      check("exc_drain_pcsel", PC_Sel, 0);
    end
    next_cycle(); idle(); mid();
    check("exc_vec_pcsel", PC_Sel, 2);
    check("exc_vec_pcw", PC_Write, 1);
    check("exc_vec_ifidw", IFID_Write, 1);
    check("exc_vec_flush", flushes(), 0);
    check("exc_vec_pend", Exc_Pending, 1);
    next_cycle(); mid();
    check("exc_ret_pcsel", PC_Sel, 0);
    check("exc_ret_pend", Exc_Pending, 0);
    check("exc_ret_flush", flushes(), 0);
    check("exc_flushcnt", FlushCnt, 3);

    // Reset during drain returns to RUN and clears everything.
    next_cycle(); M_Overflow = 1; M_RegWr = 1; mid();
    next_cycle(); idle(); mid();
    check("rd_pend", Exc_Pending, 1);
    next_cycle(); Reset = 1; mid();
    check("rd_rst_flush", flushes(), 3'b111);
    next_cycle(); Reset = 0; mid();
    check("rd_pcw", PC_Write, 1);
    check("rd_pcsel", PC_Sel, 0);
    check("rd_pend_clr", Exc_Pending, 0);
    check("rd_flushcnt", FlushCnt, 0);
    check("rd_stallcnt", StallCnt, 0);
    next_cycle(); mid();
    check("rd_stays_run", flushes(), 0);

    // Forwarding priority and r0 exclusion.
    next_cycle(); E_Rs = 5; M_Rw = 5; W_Rw = 5; M_RegWr = 1; W_RegWr = 1; mid();
    check("fwda_mem", FwdA, 2'b01);
    next_cycle(); M_RegWr = 0; mid();
    check("fwda_wb", FwdA, 2'b10);
    next_cycle(); W_RegWr = 0; mid();
    check("fwda_rf", FwdA, 2'b00);
    next_cycle(); E_Rt = 0; M_Rw = 0; W_Rw = 0; M_RegWr = 1; W_RegWr = 1; mid();
    check("fwdb_r0", FwdB, 2'b00);
    next_cycle(); E_Rt = 7; M_Rw = 7; mid();
    check("fwdb_mem", FwdB, 2'b01);
    next_cycle(); M_Rw = 3; W_Rw = 7; mid();
    check("fwdb_wb", FwdB, 2'b10);

    // Counter saturation under a held load-use hazard.
    next_cycle(); idle(); load_use_rs(5'd4);
    repeat (65534) next_cycle();
    mid();
    check("sat_near", StallCnt, 16'hFFFE);
    repeat (5) next_cycle();
    mid();
    check("sat_hold", StallCnt, 16'hFFFF);
    check("sat_flushcnt", FlushCnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
